// File: rtl/clken_frac_gen.sv
// Fractional clock-enable generator: per-channel num/den phase accumulators gated by a lock-settle FSM.
// Optional CLKEN_WRAP_ALIGN_EN defers writes to running channels until their next enable pulse.
module clken_frac_gen #(
  parameter int CHANNELS   = 4,
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 256
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                lock,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] clken,
  output logic                ready,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

  state_t              r_state;
  logic                r_lock_s1;
  logic                r_lock_s2;
  logic                r_ready;
  logic [15:0]         r_settle_cnt;
  logic [ACC_W-1:0]    r_num [0:CHANNELS-1];
  logic [ACC_W-1:0]    r_den [0:CHANNELS-1];
  logic [ACC_W-1:0]    r_acc [0:CHANNELS-1];
  logic [CHANNELS-1:0] r_clken;

  logic [ACC_W:0]      w_sum     [0:CHANNELS-1];
  logic [ACC_W-1:0]    w_acc_nxt [0:CHANNELS-1];
  logic [CHANNELS-1:0] w_clk_nxt;
  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_apply;
  logic [ACC_W-1:0]    w_apply_num;
  logic [ACC_W-1:0]    w_apply_den;
  logic                w_stay_run;
  logic                w_wr;
  logic                w_hold;

  // cfg handshake: a write is taken on a rising edge with cfg_valid=1 and cfg_ready=1;
  // while cfg_ready=0 the cfg_* inputs are ignored.
  assign w_stay_run = (r_state == RUN) && r_lock_s2;
  assign w_wr       = cfg_valid && cfg_ready;

  always_comb begin
    w_clk_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum[c]     = {1'b0, r_acc[c]} + {1'b0, r_num[c]};
      w_acc_nxt[c] = '0;
      if (r_den[c] != '0) begin
        if (r_num[c] >= r_den[c]) begin
          w_clk_nxt[c] = 1'b1;
        end else if (w_sum[c] >= {1'b0, r_den[c]}) begin
          w_acc_nxt[c] = ACC_W'(w_sum[c] - {1'b0, r_den[c]});
          w_clk_nxt[c] = 1'b1;
        end else begin
          w_acc_nxt[c] = w_sum[c][ACC_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_load = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_load[c] = w_wr && !w_hold && (cfg_ch == 3'(c));
    end
  end

`ifdef CLKEN_WRAP_ALIGN_EN
  logic             r_pend;
  logic [2:0]       r_pend_ch;
  logic [ACC_W-1:0] r_pend_num;
  logic [ACC_W-1:0] r_pend_den;
  logic             w_tgt_busy;
  logic             w_pend_pulse;

  always_comb begin
    w_tgt_busy = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((cfg_ch == 3'(c)) && (r_den[c] != '0)) w_tgt_busy = 1'b1;
    end
  end

  assign w_hold = w_wr && w_stay_run && w_tgt_busy;

  // The held write lands right after the target's pulse, or at once if RUN is being left.
  always_comb begin
    w_apply      = '0;
    w_pend_pulse = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_pend_ch == 3'(c)) w_pend_pulse = r_clken[c];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_pend_ch == 3'(c)) w_apply[c] = r_pend && (w_pend_pulse || !w_stay_run);
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_pend_ch  <= '0;
      r_pend_num <= '0;
      r_pend_den <= '0;
    end else if (|w_apply) begin
      r_pend <= 1'b0;
    end else if (w_hold) begin
      r_pend     <= 1'b1;
      r_pend_ch  <= cfg_ch;
      r_pend_num <= cfg_num;
      r_pend_den <= cfg_den;
    end
  end

  assign w_apply_num = r_pend_num;
  assign w_apply_den = r_pend_den;
  assign cfg_ready   = ~reset & ~r_pend;
`else
  assign w_hold      = 1'b0;
  assign w_apply     = '0;
  assign w_apply_num = '0;
  assign w_apply_den = '0;
  assign cfg_ready   = ~reset;
`endif

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_LOCK;
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
      r_ready      <= 1'b0;
      r_settle_cnt <= '0;
      r_clken      <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_num[c] <= '0;
        r_den[c] <= '0;
        r_acc[c] <= '0;
      end
    end else begin
      r_lock_s1 <= lock;
      r_lock_s2 <= r_lock_s1;
      case (r_state)
        WAIT_LOCK: begin
          r_ready <= 1'b0;
          if (r_lock_s2) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!r_lock_s2) begin
            r_state <= WAIT_LOCK;
            r_ready <= 1'b0;
          end else if (r_settle_cnt == 16'(SETTLE_CYC - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!r_lock_s2) begin
            r_state <= WAIT_LOCK;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_ready <= 1'b0;
        end
      endcase
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_apply[c]) begin
          r_num[c]   <= w_apply_num;
          r_den[c]   <= w_apply_den;
          r_acc[c]   <= '0;
          r_clken[c] <= 1'b0;
        end else if (w_load[c]) begin
          r_num[c]   <= cfg_num;
          r_den[c]   <= cfg_den;
          r_acc[c]   <= '0;
          r_clken[c] <= 1'b0;
        end else if (w_stay_run) begin
          r_acc[c]   <= w_acc_nxt[c];
          r_clken[c] <= w_clk_nxt[c];
        end else begin
          r_acc[c]   <= '0;
          r_clken[c] <= 1'b0;
        end
      end
    end
  end

  assign clken       = r_clken;
  assign ready       = r_ready;
  assign o_dbg_state = r_state;

endmodule

// File: doc/clken_frac_gen.md
CLKEN_FRAC_GEN -- requirements
Module: clken_frac_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, meaning number of independent clock-enable channels (legal 1..8).
REQ-002 SHALL have parameter ACC_W, default 16, meaning width of each channel's numerator, denominator and phase accumulator.
REQ-003 SHALL have parameter SETTLE_CYC, default 256, meaning cycles lock must stay high before enables start (legal 1..65535).
REQ-004 SHALL have port clkin  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port lock  input  1  PLL lock indication, asynchronous to clkin.
REQ-007 SHALL have port cfg_valid  input  1  configuration write request.
REQ-008 SHALL have port cfg_ready  output  1  configuration write can be accepted.
REQ-009 SHALL have port cfg_ch  input  3  target channel index.
REQ-010 SHALL have port cfg_num  input  ACC_W  new numerator (enable pulses per period).
REQ-011 SHALL have port cfg_den  input  ACC_W  new denominator (period in clkin cycles).
REQ-012 SHALL have port clken  output  CHANNELS  one-cycle enable pulse per channel.
REQ-013 SHALL have port ready  output  1  lock synchronised and settled; enables running.

Function
REQ-014 SHALL synchronise lock through two flops before any use.
REQ-015 SHALL run a settle state machine: WAIT_LOCK -> SETTLE on synced lock=1; SETTLE -> RUN after SETTLE_CYC consecutive cycles of synced lock=1; any state -> WAIT_LOCK on synced lock=0.
REQ-016 SHALL drive ready=1 only in RUN, registered.
REQ-017 SHALL, outside RUN, hold all accumulators at 0 and all clken bits at 0.
REQ-018 SHALL, in RUN, per channel compute s = acc + num with ACC_W+1 bits; if s >= den then acc <= s - den and clken[ch] <= 1, else acc <= s and clken[ch] <= 0.
REQ-019 SHALL treat den=0 as channel disabled: clken[ch]=0, acc held at 0.
REQ-020 SHALL treat num=0 as never pulsing and num>=den (den!=0) as pulsing every RUN cycle with acc forced to 0.
REQ-021 SHALL register clken; first possible pulse is the second cycle of RUN.
REQ-022 SHALL accept a write on the rising edge where cfg_valid=1 and cfg_ready=1; cfg_ch >= CHANNELS is accepted and discarded.
REQ-023 SHALL, on accepted write to an idle channel (den=0 or state not RUN), load num/den and clear acc in the next cycle.
REQ-024 SHALL keep cfg_valid/cfg_ch/cfg_num/cfg_den ignored while cfg_ready=0; no write is lost or duplicated.
REQ-025 SHALL, on lock loss mid-operation, drop ready and clken within 3 cycles of lock falling, keeping num/den values.

Reset
REQ-026 SHALL on reset assertion immediately force: state WAIT_LOCK, ready=0, clken=0, all acc=0, all num=0, all den=0, sync flops 0, settle counter 0, pending flags cleared.
REQ-027 SHALL drive cfg_ready=1 while reset is deasserted and no update is pending; cfg_ready=0 during reset.

Configuration
REQ-028 SHALL honour macro CLKEN_WRAP_ALIGN_EN.
REQ-029 SHALL, with CLKEN_WRAP_ALIGN_EN defined, hold a write to a running channel (RUN, den!=0) as pending, apply it in the cycle after that channel's next clken pulse (acc cleared), and drive cfg_ready=0 from the cycle after acceptance until applied; lock loss applies pending immediately.
REQ-030 SHALL, without CLKEN_WRAP_ALIGN_EN, apply every accepted write in the next cycle with acc cleared, and keep cfg_ready=1 except during reset.

Verification
REQ-031 SHALL cover: lock=1 held, SETTLE_CYC=256 -> ready rises 2+256+1 cycles after lock (±1), clken all 0 before.
REQ-032 SHALL cover: ch0 num=1 den=3 in RUN -> clken[0] exactly every 3rd cycle, 1000 pulses per 3000 cycles.
REQ-033 SHALL cover: ch1 num=3 den=8 -> 3 pulses per every 8-cycle window, pattern repeating exactly, never two adjacent pulses.
REQ-034 SHALL cover: num=5 den=5 -> continuous clken; den=0 -> no pulses; cfg_ch=7 with CHANNELS=4 -> accepted, no channel changes.
REQ-035 SHALL cover: lock dropped for 1 cycle during RUN -> ready and clken 0 within 3 cycles, full SETTLE_CYC re-wait, then pulses resume with stored num/den.
REQ-036 SHALL cover: with CLKEN_WRAP_ALIGN_EN, ch0 num=1 den=100 rewritten to den=10 mid-period -> cfg_ready low until next ch0 pulse, then pulses every 10 cycles; without the macro, switch in next cycle.
